// File: rtl/mps_isa_pkg.sv
// Shared ISA constants: format codes, field widths and bit offsets of the 32-bit
// instruction word. Used by the encoder now and by decode logic later.
package mps_isa_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  localparam int WORD_W  = 32;
  localparam int FMT_W   = 2;
  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNC_W  = 6;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_LSB  = 0;
  localparam int IMM_LSB   = 0;
  localparam int JADDR_LSB = 0;

  // R carries op=0; I and J need a non-zero op; the reserved format is never legal.
  function automatic logic fields_legal(input logic [FMT_W-1:0] fmt, input logic [OP_W-1:0] op);
    case (fmt_e'(fmt))
      FMT_R:   fields_legal = (op == '0);
      FMT_I,
      FMT_J:   fields_legal = (op != '0);
      default: fields_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-set input stream, encoded-word output stream and error flag of instr_encoder.
// Both streams: a transfer happens on a rising clk edge where valid and ready are both high.
interface instr_encoder_if
  import mps_isa_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic                in_valid;
  logic                in_ready;
  logic [FMT_W-1:0]    fmt;
  logic [OP_W-1:0]     op;
  logic [FUNC_W-1:0]   func;
  logic [REG_W-1:0]    reg_s;
  logic [REG_W-1:0]    reg_t;
  logic [REG_W-1:0]    reg_d;
  logic [SHAMT_W-1:0]  shamt;
  logic [IMM_W-1:0]    imm;
  logic [JADDR_W-1:0]  jump_addr;
  logic                addr_load;
  logic [ADDR_W-1:0]   addr_in;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   out_word;
  logic [ADDR_W-1:0]   out_addr;
  logic                err;

  modport master (
    output in_valid, fmt, op, func, reg_s, reg_t, reg_d, shamt, imm, jump_addr,
    output addr_load, addr_in, out_ready,
    input  in_ready, out_valid, out_word, out_addr, err
  );

  modport slave (
    input  in_valid, fmt, op, func, reg_s, reg_t, reg_d, shamt, imm, jump_addr,
    input  addr_load, addr_in, out_ready,
    output in_ready, out_valid, out_word, out_addr, err
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational packing of a field set into a 32-bit instruction word.
// The reserved format packs like R.
module instr_pack
  import mps_isa_pkg::*;
(
  input  logic [FMT_W-1:0]   fmt_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [FUNC_W-1:0]  func_i,
  input  logic [REG_W-1:0]   reg_s_i,
  input  logic [REG_W-1:0]   reg_t_i,
  input  logic [REG_W-1:0]   reg_d_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [IMM_W-1:0]   imm_i,
  input  logic [JADDR_W-1:0] jump_addr_i,
  output logic [WORD_W-1:0]  word_o
);
  always_comb begin
    word_o = '0;
    word_o[OP_LSB +: OP_W] = op_i;
    case (fmt_e'(fmt_i))
      FMT_I: begin
        word_o[RS_LSB +: REG_W]  = reg_s_i;
        word_o[RT_LSB +: REG_W]  = reg_t_i;
        word_o[IMM_LSB +: IMM_W] = imm_i;
      end
      FMT_J: begin
        word_o[JADDR_LSB +: JADDR_W] = jump_addr_i;
      end
      default: begin
        word_o[RS_LSB +: REG_W]        = reg_s_i;
        word_o[RT_LSB +: REG_W]        = reg_t_i;
        word_o[RD_LSB +: REG_W]        = reg_d_i;
        word_o[SHAMT_LSB +: SHAMT_W]   = shamt_i;
        word_o[FUNC_LSB +: FUNC_W]     = func_i;
      end
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one-deep output register, word-address counter, optional
// field checker enabled by the INSTR_ENC_CHECK_EN macro (err tied low otherwise).
module instr_encoder
  import mps_isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
)(
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus
);
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_word_q,  out_word_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              err_q,       err_d;
  logic [WORD_W-1:0] packed_word;
  logic              accept, out_hs, illegal;

  instr_pack u_pack (
    .fmt_i       (bus.fmt),
    .op_i        (bus.op),
    .func_i      (bus.func),
    .reg_s_i     (bus.reg_s),
    .reg_t_i     (bus.reg_t),
    .reg_d_i     (bus.reg_d),
    .shamt_i     (bus.shamt),
    .imm_i       (bus.imm),
    .jump_addr_i (bus.jump_addr),
    .word_o      (packed_word)
  );

  assign bus.in_ready = rst_n & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign out_hs       = out_valid_q & bus.out_ready;

`ifdef INSTR_ENC_CHECK_EN
  assign illegal = ~fields_legal(bus.fmt, bus.op);
`else
  assign illegal = 1'b0;
`endif

  // An illegal set is consumed but leaves the output register empty.
  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (accept) begin
      out_valid_d = ~illegal;
      if (!illegal) out_word_d = packed_word;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  // The pending word always reports the live counter, so a load retargets it.
  always_comb begin
    out_addr_d = out_addr_q;
    if (bus.addr_load)   out_addr_d = bus.addr_in;
    else if (out_hs)     out_addr_d = out_addr_q + 1'b1;
  end

  assign err_d = err_q | (accept & illegal);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= ADDR_W'(BASE_ADDR);
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.err       = err_q;
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, width of word-address counter.
REQ-002 SHALL have parameter BASE_ADDR, default 0, address loaded at reset.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, field set valid.
REQ-006 SHALL have port in_ready, output, 1, encoder accepts field set.
REQ-007 SHALL have port fmt, input, 2, format: 0=R, 1=I, 2=J, 3=reserved.
REQ-008 SHALL have ports op and func, input, 6 each, opcode and function fields.
REQ-009 SHALL have ports reg_s, reg_t, reg_d and shamt, input, 5 each, register and shift fields.
REQ-010 SHALL have ports imm, input, 16, and jump_addr, input, 26, immediate and jump target fields.
REQ-011 SHALL have port addr_load, input, 1, and addr_in, input, ADDR_W, counter load strobe and value.
REQ-012 SHALL have ports out_valid, output, 1, out_ready, input, 1, out_word, output, 32, out_addr, output, ADDR_W, encoded-word stream.
REQ-013 SHALL have port err, output, 1, sticky encode-error flag.

Function
REQ-014 SHALL pack R as {op,reg_s,reg_t,reg_d,shamt,func}, I as {op,reg_s,reg_t,imm} and J as {op,jump_addr}, with op at bits 31:26, reg_s at 25:21, reg_t at 20:16, reg_d at 15:11 and func at 5:0.
REQ-015 SHALL accept a field set when in_valid and in_ready are both high; this is the accept event.
REQ-016 SHALL register the packed word on accept; out_valid rises the next cycle (latency 1).
REQ-017 SHALL drive in_ready = !out_valid || out_ready, giving full throughput with a single output register.
REQ-018 SHALL hold out_word and out_addr stable while out_valid is high and out_ready is low.
REQ-019 SHALL increment out_addr by 1 on each output handshake (out_valid && out_ready), wrapping from 2^ADDR_W-1 to 0.
REQ-020 SHALL load addr_in into the counter on addr_load; load wins over a simultaneous handshake increment.
REQ-021 SHALL apply addr_load without dropping a pending word; the pending word takes the loaded address.
REQ-022 SHALL allow simultaneous output handshake and new accept in one cycle, with no bubble.

Reset
REQ-023 SHALL, on rst_n low at a clock edge, set out_valid=0, out_word=0, out_addr=BASE_ADDR and err=0, discarding any pending word.
REQ-024 SHALL hold in_ready at 0 during a cycle in which rst_n is low.

Configuration
REQ-025 SHALL, with INSTR_ENC_CHECK_EN defined, treat as illegal any R format with op!=0, any fmt=3, and any I or J format with op=0; an illegal field set is accepted but dropped (no out_valid), and err is set and held until reset.
REQ-026 SHALL, without INSTR_ENC_CHECK_EN, tie err to 0, encode fmt=3 as R, and pass all fields unchecked.

Structure
REQ-027 SHALL place format codes, field widths and bit-offset constants in shared package mps_isa_pkg, which future decode logic also uses.
REQ-028 SHALL isolate the combinational packing in sub-module instr_pack; instr_encoder holds the handshake, output register, counter and checker.

Verification
REQ-029 SHALL cover R encoding: fmt=0, op=0, rs=1, rt=2, rd=3, shamt=0, func=0x20 -> out_word=0x00221820 at out_addr=0, one cycle after accept.
REQ-030 SHALL cover I and J encoding: fmt=1, op=0x08, rs=1, rt=2, imm=0xFFFF -> 0x2022FFFF; then fmt=2, op=0x02, jump_addr=0x100 -> 0x08000100 at out_addr=1.
REQ-031 SHALL cover backpressure: out_ready low 3 cycles with a word pending -> in_ready=0, out_word and out_addr stable, no word lost or duplicated.
REQ-032 SHALL cover wrap and load: ADDR_W=2, 5 handshakes -> addresses 0,1,2,3,0; addr_load with addr_in=2 on the same cycle as a handshake -> next address 2.
REQ-033 SHALL cover the checker: with INSTR_ENC_CHECK_EN, fmt=0 and op=0x08 -> no out_valid and err=1 sticky; without the macro -> word emitted and err=0.
REQ-034 SHALL cover reset mid-stream: rst_n low while out_valid=1 -> next cycle out_valid=0, out_addr=BASE_ADDR and err=0.
